// File: rtl/i2c_reg_seq.sv
// i2c_reg_seq: register-level request sequencer driving an i2cMaster Avalon-MM slave port.
// Latency: per byte about 3 setup cycles + I2C byte time + 4 cycles; init takes 3 cycles after reset.
// Backpressure: reqReady is high only while idle; one request is in flight at a time, with no queueing.
//
// Ports:
//   clk, reset            system clock and synchronous active-high reset
//   req*                  request handshake (valid/ready), op select, device/register address, write data
//   rsp*                  one-cycle completion pulse with read data and error code
//                         ({timeout, cmdErr[1:0]})
//   avm*                  Avalon-MM master into i2cMaster avs* (registered single-cycle pulses)
//   insIrq                i2cMaster byte-done interrupt
//
// Build option: define I2C_SEQ_POLL_EN to run the core with its interrupt disabled.
// The sequencer then polls the irq flag register instead of watching insIrq.

module i2c_reg_seq #(
  parameter int TIMEOUT_CLKS = 1_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       reqValid,
  output logic       reqReady,
  input  logic       reqRd,
  input  logic [6:0] reqDevAdr,
  input  logic [7:0] reqRegAdr,
  input  logic [7:0] reqWrData,
  output logic       rspValid,
  output logic [7:0] rspRdData,
  output logic [2:0] rspErr,
  output logic [1:0] avmAdr,
  output logic       avmWr,
  output logic [7:0] avmWrData,
  output logic       avmRd,
  input  logic [7:0] avmRdData,
  input  logic       insIrq
);

  localparam int CNT_W = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CLKS - 1);

  // i2cMaster register map
  localparam logic [1:0] ADR_CTRL = 2'd0;
  localparam logic [1:0] ADR_IRQ  = 2'd1;
  localparam logic [1:0] ADR_DATA = 2'd2;
  localparam logic [1:0] ADR_CMD  = 2'd3;

  localparam logic [7:0] CTRL_SRST = 8'h01;
`ifdef I2C_SEQ_POLL_EN
  localparam logic [7:0] CTRL_EN = 8'h80;
`else
  localparam logic [7:0] CTRL_EN = 8'hC0;
`endif

  typedef enum logic [3:0] {
    INIT_SRST = 4'd0,
    INIT_EN   = 4'd1,
    IDLE      = 4'd2,
    LOAD      = 4'd3,
    CMD       = 4'd4,
    WAIT_IRQ  = 4'd5,
    RD_STAT   = 4'd6,
    STAT_CAP  = 4'd7,
    CLR_IRQ   = 4'd8,
    RD_DATA   = 4'd9,
    DATA_CAP  = 4'd10,
    RESP      = 4'd11
  } state_t;

  state_t state, nextState;

  // Latched request
  logic       latRd;
  logic [6:0] latDev;
  logic [7:0] latReg;
  logic [7:0] latWd;

  logic [1:0]       stepIdx;
  logic [CNT_W-1:0] toCnt;
  logic             abortPend;
  logic             irqSeen;

  // Step table view
  logic       curRd;
  logic [6:0] curDev;
  logic [7:0] curReg;
  logic [7:0] curWd;
  logic [1:0] stepSel;
  logic [7:0] stepByte;
  logic [7:0] stepCmd;
  logic       lastStep;

  // Next values for the registered bus outputs
  logic [1:0] avmAdrNxt;
  logic       avmWrNxt;
  logic [7:0] avmWrDataNxt;
  logic       avmRdNxt;

`ifdef I2C_SEQ_POLL_EN
  // Poll phase 0 issues the irq-flag read, phase 1 sees its data.
  logic pollPhase;
  logic pollNext;
  assign pollNext = (state == WAIT_IRQ) ? ~pollPhase : 1'b0;
  assign irqSeen  = pollPhase & avmRdData[0];

  always_ff @(posedge clk) begin
    if (reset) pollPhase <= 1'b0;
    else       pollPhase <= pollNext;
  end
`else
  assign irqSeen = insIrq;
`endif

  // Byte/command for the step about to be loaded. In IDLE the request is being
  // accepted this edge, so the live request fields are used. In CLR_IRQ the step
  // index advances on the same edge that LOAD is entered.
  always_comb begin
    curRd  = latRd;
    curDev = latDev;
    curReg = latReg;
    curWd  = latWd;
    if (state == IDLE) begin
      curRd  = reqRd;
      curDev = reqDevAdr;
      curReg = reqRegAdr;
      curWd  = reqWrData;
    end

    stepSel = stepIdx;
    if (state == IDLE)         stepSel = 2'd0;
    else if (state == CLR_IRQ) stepSel = stepIdx + 2'd1;

    stepByte = 8'h00;
    stepCmd  = 8'h00;
    case (stepSel)
      2'd0: begin stepByte = {curDev, 1'b0}; stepCmd = 8'hC0; end
      2'd1: begin stepByte = curReg;         stepCmd = 8'h40; end
      2'd2: begin
        if (curRd) begin stepByte = {curDev, 1'b1}; stepCmd = 8'hC0; end
        else       begin stepByte = curWd;          stepCmd = 8'h50; end
      end
      default: begin stepByte = 8'h00; stepCmd = 8'h10; end
    endcase

    lastStep = latRd ? (stepIdx == 2'd3) : (stepIdx == 2'd2);
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= INIT_SRST;
    else       state <= nextState;
  end

  // Next-state logic
  always_comb begin
    nextState = state;
    case (state)
      // After reset the soft-reset write has not gone out yet, so stay until
      // the registered write pulse is seen on the bus.
      INIT_SRST: if (avmWr) nextState = INIT_EN;
      INIT_EN:   nextState = abortPend ? RESP : IDLE;
      IDLE:      if (reqValid && reqReady) nextState = LOAD;
      LOAD:      nextState = CMD;
      CMD:       nextState = WAIT_IRQ;
      WAIT_IRQ: begin
        if (irqSeen)                nextState = RD_STAT;
        else if (toCnt == CNT_LAST) nextState = INIT_SRST;
      end
      RD_STAT:   nextState = STAT_CAP;
      STAT_CAP:  nextState = (avmRdData[1:0] != 2'b00) ? INIT_SRST : CLR_IRQ;
      CLR_IRQ: begin
        if (!lastStep)  nextState = LOAD;
        else if (latRd) nextState = RD_DATA;
        else            nextState = RESP;
      end
      RD_DATA:   nextState = DATA_CAP;
      DATA_CAP:  nextState = RESP;
      RESP:      nextState = IDLE;
      default:   nextState = INIT_SRST;
    endcase
  end

  // Bus outputs are decoded from the next state and registered, so each access
  // is active during the state that issues it and read data lands in the state after.
  always_comb begin
    avmAdrNxt    = 2'd0;
    avmWrNxt     = 1'b0;
    avmWrDataNxt = 8'h00;
    avmRdNxt     = 1'b0;
    case (nextState)
      INIT_SRST: begin avmWrNxt = 1'b1; avmAdrNxt = ADR_CTRL; avmWrDataNxt = CTRL_SRST; end
      INIT_EN:   begin avmWrNxt = 1'b1; avmAdrNxt = ADR_CTRL; avmWrDataNxt = CTRL_EN;   end
      LOAD:      begin avmWrNxt = 1'b1; avmAdrNxt = ADR_DATA; avmWrDataNxt = stepByte;  end
      CMD:       begin avmWrNxt = 1'b1; avmAdrNxt = ADR_CMD;  avmWrDataNxt = stepCmd;   end
`ifdef I2C_SEQ_POLL_EN
      WAIT_IRQ:  if (!pollNext) begin avmRdNxt = 1'b1; avmAdrNxt = ADR_IRQ; end
`endif
      RD_STAT:   begin avmRdNxt = 1'b1; avmAdrNxt = ADR_CMD; end
      CLR_IRQ:   begin avmWrNxt = 1'b1; avmAdrNxt = ADR_IRQ; avmWrDataNxt = 8'h00; end
      RD_DATA:   begin avmRdNxt = 1'b1; avmAdrNxt = ADR_DATA; end
      default:   ;
    endcase
  end

  // Registered outputs and datapath
  always_ff @(posedge clk) begin
    if (reset) begin
      reqReady  <= 1'b0;
      rspValid  <= 1'b0;
      rspRdData <= 8'h00;
      rspErr    <= 3'b000;
      avmAdr    <= 2'd0;
      avmWr     <= 1'b0;
      avmWrData <= 8'h00;
      avmRd     <= 1'b0;
      stepIdx   <= 2'd0;
      toCnt     <= '0;
      abortPend <= 1'b0;
      latRd     <= 1'b0;
      latDev    <= 7'h00;
      latReg    <= 8'h00;
      latWd     <= 8'h00;
    end else begin
      avmAdr    <= avmAdrNxt;
      avmWr     <= avmWrNxt;
      avmWrData <= avmWrDataNxt;
      avmRd     <= avmRdNxt;
      reqReady  <= (nextState == IDLE);
      rspValid  <= (nextState == RESP);

      case (state)
        IDLE: begin
          if (reqValid && reqReady) begin
            latRd     <= reqRd;
            latDev    <= reqDevAdr;
            latReg    <= reqRegAdr;
            latWd     <= reqWrData;
            stepIdx   <= 2'd0;
            rspErr    <= 3'b000;
            rspRdData <= 8'h00;
          end
        end
        CMD: toCnt <= '0;
        WAIT_IRQ: begin
          toCnt <= toCnt + 1'b1;
          if (nextState == INIT_SRST) begin
            rspErr    <= 3'b100;
            abortPend <= 1'b1;
          end
        end
        STAT_CAP: begin
          if (avmRdData[1:0] != 2'b00) begin
            rspErr    <= {1'b0, avmRdData[1:0]};
            abortPend <= 1'b1;
          end
        end
        CLR_IRQ:  if (!lastStep) stepIdx <= stepIdx + 2'd1;
        DATA_CAP: rspRdData <= avmRdData;
        INIT_EN:  abortPend <= 1'b0;
        default:  ;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_reg_seq.sv
module tb_i2c_reg_seq;

  localparam int TO = 2000;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       reqValid = 1'b0;
  logic       reqRd = 1'b0;
  logic [6:0] reqDevAdr = 7'h00;
  logic [7:0] reqRegAdr = 8'h00;
  logic [7:0] reqWrData = 8'h00;
  logic       reqReady;
  logic       rspValid;
  logic [7:0] rspRdData;
  logic [2:0] rspErr;
  logic [1:0] avmAdr;
  logic       avmWr;
  logic [7:0] avmWrData;
  logic       avmRd;
  logic [7:0] avmRdData = 8'h00;
  logic       insIrq;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  i2c_reg_seq #(.TIMEOUT_CLKS(TO)) dut (
    .clk(clk), .reset(reset),
    .reqValid(reqValid), .reqReady(reqReady), .reqRd(reqRd),
    .reqDevAdr(reqDevAdr), .reqRegAdr(reqRegAdr), .reqWrData(reqWrData),
    .rspValid(rspValid), .rspRdData(rspRdData), .rspErr(rspErr),
    .avmAdr(avmAdr), .avmWr(avmWr), .avmWrData(avmWrData), .avmRd(avmRd),
    .avmRdData(avmRdData), .insIrq(insIrq)
  );

  // Behavioural i2cMaster register model: logs every byte/command pair and ctrl
  // write, raises the byte-done flag byteTime cycles after a command write.
  int          byteTime = 20;
  int          nackAt = -1;
  logic [7:0]  rxData = 8'h00;
  logic        noIrq = 1'b0;
  logic        irqEn = 1'b0;
  logic        irqFlag = 1'b0;
  int          irqCnt = 0;
  logic [7:0]  txByte = 8'h00;
  logic [15:0] cmdLog[$];
  logic [7:0]  ctrlLog[$];
  int          ctrlCyc[$];
  int          mdlCyc = 0, lastCmdCyc = 0, rspCnt = 0, bothCnt = 0, idleBad = 0, rdCnt = 0, wrCnt = 0;

  assign insIrq = irqFlag & irqEn;

  always @(posedge clk) begin
    mdlCyc <= mdlCyc + 1;
    if (rspValid) rspCnt <= rspCnt + 1;
    if (avmWr && avmRd) bothCnt <= bothCnt + 1;
    if (!avmWr && !avmRd && (avmAdr != 2'd0 || avmWrData != 8'h00)) idleBad <= idleBad + 1;
    if (irqCnt > 0) begin
      if (irqCnt == 1) irqFlag <= 1'b1;
      irqCnt <= irqCnt - 1;
    end
    if (avmWr) begin
      wrCnt <= wrCnt + 1;
      case (avmAdr)
        2'd0: begin
          ctrlLog.push_back(avmWrData);
          ctrlCyc.push_back(mdlCyc);
          if (avmWrData == 8'h01) begin
            irqEn <= 1'b0; irqFlag <= 1'b0; irqCnt <= 0;
          end else irqEn <= avmWrData[6];
        end
        2'd1: irqFlag <= avmWrData[0];
        2'd2: txByte <= avmWrData;
        default: begin
          cmdLog.push_back({txByte, avmWrData});
          lastCmdCyc <= mdlCyc;
          if (!noIrq) irqCnt <= byteTime;
        end
      endcase
    end
    if (avmRd) begin
      rdCnt <= rdCnt + 1;
      case (avmAdr)
        2'd1:    avmRdData <= {7'b0, irqFlag};
        2'd2:    avmRdData <= rxData;
        2'd3:    avmRdData <= {6'b0, ((cmdLog.size() - 1) == nackAt) ? 2'b01 : 2'b00};
        default: avmRdData <= 8'h00;
      endcase
    end
  end

  // Stimulus: issue one request and wait (bounded) for its response pulse.
  task automatic do_req(input logic rd, input logic [6:0] dev, input logic [7:0] ra,
                        input logic [7:0] wd, input int budget,
                        output logic got, output logic [7:0] rdd, output logic [2:0] err);
    int n;
    got = 1'b0; rdd = 8'hxx; err = 3'bxxx;
    reqRd = rd; reqDevAdr = dev; reqRegAdr = ra; reqWrData = wd; reqValid = 1'b1;
    n = 0;
    while (reqReady !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    @(negedge clk);
    reqValid = 1'b0; reqRd = 1'b0; reqDevAdr = 7'h00; reqRegAdr = 8'h00; reqWrData = 8'h00;
    n = 0;
    while (n < budget) begin
      if (rspValid === 1'b1) begin
        got = 1'b1; rdd = rspRdData; err = rspErr;
        break;
      end
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset();
    int n;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (reqReady !== 1'b0) begin errors++; $display("FAIL reset_reqReady got %b want 0", reqReady); end
    checks++; if (rspValid !== 1'b0) begin errors++; $display("FAIL reset_rspValid got %b want 0", rspValid); end
    checks++; if ({avmWr, avmRd, avmAdr, avmWrData} !== 12'h000) begin errors++;
      $display("FAIL reset_avm got wr=%b rd=%b adr=%h dat=%h want all 0", avmWr, avmRd, avmAdr, avmWrData); end
    checks++; if ({rspErr, rspRdData} !== 11'h000) begin errors++;
      $display("FAIL reset_rsp got err=%b data=%h want 0", rspErr, rspRdData); end
    reset = 1'b0;
    n = 0;
    while (reqReady !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    checks++; if (reqReady !== 1'b1) begin errors++; $display("FAIL init_ready got %b want 1", reqReady); end
    checks++; if (ctrlLog.size() != 2 || ctrlLog[0] !== 8'h01 || ctrlLog[1] !== 8'hC0) begin errors++;
      $display("FAIL init_ctrl got %0d ctrl writes want 2 (01,C0)", ctrlLog.size()); end
    repeat (20) @(negedge clk);
    checks++; if (wrCnt != 2 || rdCnt != 0 || cmdLog.size() != 0) begin errors++;
      $display("FAIL init_traffic got wr=%0d rd=%0d cmd=%0d want 2/0/0", wrCnt, rdCnt, cmdLog.size()); end
    checks++; if (reqReady !== 1'b1) begin errors++; $display("FAIL idle_ready got %b want 1", reqReady); end
  endtask

  task automatic test_write();
    logic got; logic [7:0] rdd; logic [2:0] err;
    int base;
    base = cmdLog.size();
    byteTime = 20;
    do_req(1'b0, 7'h1A, 8'hB9, 8'hA5, 2000, got, rdd, err);
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL wr_rsp got %b want 1", got); end
    checks++; if (err !== 3'b000 || rdd !== 8'h00) begin errors++;
      $display("FAIL wr_result got err=%b data=%h want 000/00", err, rdd); end
    checks++; if (cmdLog.size() - base != 3 || cmdLog[base] !== 16'h34C0 || cmdLog[base+1] !== 16'hB940
                  || cmdLog[base+2] !== 16'hA550) begin errors++;
      $display("FAIL wr_bytes got %0d bytes first %h want 34C0,B940,A550", cmdLog.size() - base, cmdLog[base]); end
    @(negedge clk);
    checks++; if (rspValid !== 1'b0 || reqReady !== 1'b1) begin errors++;
      $display("FAIL wr_pulse got valid=%b ready=%b want 0/1", rspValid, reqReady); end
  endtask

  task automatic test_read();
    logic got; logic [7:0] rdd; logic [2:0] err;
    int base;
    base = cmdLog.size();
    rxData = 8'hD5;
    do_req(1'b1, 7'h5E, 8'h34, 8'h77, 3000, got, rdd, err);
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL rd_rsp got %b want 1", got); end
    checks++; if (err !== 3'b000 || rdd !== 8'hD5) begin errors++;
      $display("FAIL rd_result got err=%b data=%h want 000/D5", err, rdd); end
    checks++; if (cmdLog.size() - base != 4 || cmdLog[base] !== 16'hBCC0 || cmdLog[base+1] !== 16'h3440
                  || cmdLog[base+2] !== 16'hBDC0 || cmdLog[base+3] !== 16'h0010) begin errors++;
      $display("FAIL rd_bytes got %0d bytes want BCC0,3440,BDC0,0010", cmdLog.size() - base); end
    @(negedge clk);
    checks++; if (rspValid !== 1'b0 || rspRdData !== 8'hD5) begin errors++;
      $display("FAIL rd_hold got valid=%b data=%h want 0/D5", rspValid, rspRdData); end
  endtask

  task automatic test_nack();
    logic got; logic [7:0] rdd; logic [2:0] err;
    int base, cbase;
    base = cmdLog.size(); cbase = ctrlLog.size();
    nackAt = base;
    do_req(1'b0, 7'h1A, 8'hB9, 8'hA5, 2000, got, rdd, err);
    nackAt = -1;
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL nack_rsp got %b want 1", got); end
    checks++; if (err !== 3'b001 || rdd !== 8'h00) begin errors++;
      $display("FAIL nack_result got err=%b data=%h want 001/00", err, rdd); end
    checks++; if (cmdLog.size() - base != 1) begin errors++;
      $display("FAIL nack_bytes got %0d bytes want 1", cmdLog.size() - base); end
    checks++; if (ctrlLog.size() - cbase != 2 || ctrlLog[cbase] !== 8'h01 || ctrlLog[cbase+1] !== 8'hC0) begin errors++;
      $display("FAIL nack_reinit got %0d ctrl writes want 2 (01,C0)", ctrlLog.size() - cbase); end
    @(negedge clk);
    checks++; if (reqReady !== 1'b1) begin errors++; $display("FAIL nack_ready got %b want 1", reqReady); end
  endtask

  task automatic test_timeout();
    logic got; logic [7:0] rdd; logic [2:0] err;
    int base, cbase, gap;
    base = cmdLog.size(); cbase = ctrlLog.size();
    noIrq = 1'b1;
    do_req(1'b0, 7'h11, 8'h22, 8'h33, TO + 1000, got, rdd, err);
    noIrq = 1'b0;
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL to_rsp got %b want 1", got); end
    checks++; if (err !== 3'b100 || rdd !== 8'h00) begin errors++;
      $display("FAIL to_result got err=%b data=%h want 100/00", err, rdd); end
    checks++; if (cmdLog.size() - base != 1) begin errors++;
      $display("FAIL to_bytes got %0d bytes want 1", cmdLog.size() - base); end
    gap = (ctrlLog.size() > cbase) ? ctrlCyc[cbase] - lastCmdCyc : -1;
    checks++; if (gap != TO + 1) begin errors++;
      $display("FAIL to_gap got %0d cycles cmd->srst want %0d", gap, TO + 1); end
    checks++; if (ctrlLog.size() - cbase != 2 || ctrlLog[cbase] !== 8'h01 || ctrlLog[cbase+1] !== 8'hC0) begin errors++;
      $display("FAIL to_reinit got %0d ctrl writes want 2", ctrlLog.size() - cbase); end
    @(negedge clk);
    checks++; if (reqReady !== 1'b1) begin errors++; $display("FAIL to_ready got %b want 1", reqReady); end
  endtask

  task automatic test_stretch_reset();
    logic got; logic [7:0] rdd; logic [2:0] err;
    int base, cbase, rc, n;
    base = cmdLog.size();
    byteTime = 1800;
    do_req(1'b0, 7'h20, 8'h11, 8'h22, 10000, got, rdd, err);
    checks++; if (got !== 1'b1 || err !== 3'b000) begin errors++;
      $display("FAIL stretch_result got valid=%b err=%b want 1/000", got, err); end
    checks++; if (cmdLog.size() - base != 3 || cmdLog[base] !== 16'h40C0 || cmdLog[base+1] !== 16'h1140
                  || cmdLog[base+2] !== 16'h2250) begin errors++;
      $display("FAIL stretch_bytes got %0d bytes want 40C0,1140,2250", cmdLog.size() - base); end
    @(negedge clk);
    base = cmdLog.size(); cbase = ctrlLog.size(); rc = rspCnt;
    reqRd = 1'b0; reqDevAdr = 7'h20; reqRegAdr = 8'h11; reqWrData = 8'h22; reqValid = 1'b1;
    @(negedge clk);
    reqValid = 1'b0;
    repeat (300) @(negedge clk);
    checks++; if (cmdLog.size() - base != 1) begin errors++;
      $display("FAIL midbyte_bytes got %0d bytes want 1", cmdLog.size() - base); end
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    n = 0;
    while (reqReady !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    repeat (10) @(negedge clk);
    checks++; if (reqReady !== 1'b1) begin errors++; $display("FAIL rst_ready got %b want 1", reqReady); end
    checks++; if (rspCnt != rc) begin errors++; $display("FAIL rst_no_rsp got %0d pulses want 0", rspCnt - rc); end
    checks++; if (ctrlLog.size() - cbase != 2 || ctrlLog[cbase] !== 8'h01 || ctrlLog[cbase+1] !== 8'hC0
                  || cmdLog.size() - base != 1) begin errors++;
      $display("FAIL rst_reinit got %0d ctrl %0d cmd want 2/1", ctrlLog.size() - cbase, cmdLog.size() - base); end
    byteTime = 20;
  endtask

  task automatic test_back_to_back();
    logic got; logic [7:0] rdd; logic [2:0] err;
    rxData = 8'h3C;
    do_req(1'b1, 7'h01, 8'hFF, 8'h00, 3000, got, rdd, err);
    checks++; if (got !== 1'b1 || err !== 3'b000 || rdd !== 8'h3C) begin errors++;
      $display("FAIL b2b_rd got valid=%b err=%b data=%h want 1/000/3C", got, err, rdd); end
    do_req(1'b0, 7'h7F, 8'h00, 8'hFF, 2000, got, rdd, err);
    checks++; if (got !== 1'b1 || err !== 3'b000 || rdd !== 8'h00) begin errors++;
      $display("FAIL b2b_wr got valid=%b err=%b data=%h want 1/000/00", got, err, rdd); end
  endtask

  task automatic test_bus_rules();
    checks++; if (bothCnt != 0) begin errors++; $display("FAIL bus_wr_rd got %0d overlaps want 0", bothCnt); end
    checks++; if (idleBad != 0) begin errors++; $display("FAIL bus_idle got %0d nonzero idle cycles want 0", idleBad); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_nack();
    test_timeout();
    test_stretch_reset();
    test_back_to_back();
    test_bus_rules();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got no completion want finish");
    $fatal(1, "watchdog");
  end

endmodule
